// File: rtl/png_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// png_ctrl_pkg
// Shared types and constants for the Pong game-sequencing controller.
//   game_state_t : controller phase (ATTRACT / SERVE_WAIT / PLAY)
//   DIR_LEFT/RIGHT : serve_dir encodings
//   SCORE_W      : width of each score register
// ---------------------------------------------------------------------------
package png_ctrl_pkg;

    typedef enum logic [1:0] {
        ATTRACT    = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2
    } game_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int SCORE_W = 4;

endpackage

// File: rtl/png_frame_timer.sv
// ---------------------------------------------------------------------------
// png_frame_timer
// 8-bit loadable down-counter that counts frame ticks.
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load count with load_val (wins over tick)
//   load_val  : reload value
//   tick      : decrement strobe
//   done      : high in the cycle a tick arrives while count is 1
// ---------------------------------------------------------------------------
module png_frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       done
);

    logic [7:0] count;

    // A load in the same cycle swallows the tick, so it can never signal done.
    assign done = tick && !load && (count == 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/png_game_ctrl.sv
// ---------------------------------------------------------------------------
// png_game_ctrl
// Game-sequencing controller for the Pong core: attract/serve/play phases,
// serve delay counted in frames, and both score registers.
//   clk, rst     : clock, asynchronous active-high reset
//   vblank_tick  : one strobe per frame
//   coin         : start-game strobe (honoured only in ATTRACT)
//   miss_l       : ball left via left edge -> right player scores
//   miss_r       : ball left via right edge -> left player scores
//   attract      : high in ATTRACT
//   serve_en     : ball visible and moving (low only in SERVE_WAIT)
//   serve_dir    : launch direction, 0 = toward left, 1 = toward right
//   score_l/_r   : player scores
//   score_pulse  : one-cycle strobe on any score increment
//   game_over    : high from the winning point until the next coin
// ---------------------------------------------------------------------------
module png_game_ctrl
    import png_ctrl_pkg::*;
#(
    parameter int SERVE_DELAY = 64,
    parameter int WIN_SCORE   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank_tick,
    input  logic               coin,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               attract,
    output logic               serve_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               score_pulse,
    output logic               game_over
);

    localparam logic [7:0]         DELAY_VAL = SERVE_DELAY[7:0];
    localparam logic [SCORE_W-1:0] WIN_VAL   = WIN_SCORE[SCORE_W-1:0];

    game_state_t        state, state_nxt;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;
    logic               take_l, take_r, win;
    logic               timer_load, timer_tick, timer_done;

    assign score_l_inc = score_l + 4'd1;
    assign score_r_inc = score_r + 4'd1;

    // miss_l has priority; a simultaneous miss_r is dropped.
    assign take_l = (state == PLAY) && miss_l;
    assign take_r = (state == PLAY) && miss_r && !miss_l;
    assign win    = (take_l && (score_r_inc == WIN_VAL)) ||
                    (take_r && (score_l_inc == WIN_VAL));

    // The timer only counts in SERVE_WAIT; a reload on coin or a non-winning
    // miss wins over any coincident tick inside the timer.
    assign timer_load = ((state == ATTRACT) && coin) || ((take_l || take_r) && !win);
    assign timer_tick = (state == SERVE_WAIT) && vblank_tick;

    png_frame_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (DELAY_VAL),
        .tick     (timer_tick),
        .done     (timer_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ATTRACT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            ATTRACT: begin
                if (coin) state_nxt = SERVE_WAIT;
            end
            SERVE_WAIT: begin
                if (timer_done) state_nxt = PLAY;
            end
            PLAY: begin
                if (take_l || take_r) state_nxt = win ? ATTRACT : SERVE_WAIT;
            end
            default: state_nxt = ATTRACT;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        attract  = (state == ATTRACT);
        serve_en = (state != SERVE_WAIT);
    end

    // Scores, serve direction and event flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_l     <= '0;
            score_r     <= '0;
            serve_dir   <= DIR_LEFT;
            score_pulse <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            if ((state == ATTRACT) && coin) begin
                score_l   <= '0;
                score_r   <= '0;
                game_over <= 1'b0;
            end else if (take_l) begin
                // Next ball goes toward the player who missed.
                score_r     <= score_r_inc;
                serve_dir   <= DIR_LEFT;
                score_pulse <= 1'b1;
                if (win) game_over <= 1'b1;
            end else if (take_r) begin
                score_l     <= score_l_inc;
                serve_dir   <= DIR_RIGHT;
                score_pulse <= 1'b1;
                if (win) game_over <= 1'b1;
            end
        end
    end

endmodule
